cnu_min_sched: RTL and testbench
================================

Name: cnu_min_sched

Overview:
- Serial check-node min-sum scheduler for the LDPC decoder CNU.
- Accepts one variable-to-check message (sign + magnitude) per handshake for a row of programmable degree.
- Tracks smallest magnitude (min1), second smallest (min2), min1 index and sign parity.
- Presents the row result on a valid/ready output port for the check-to-variable update stage.

Parameters:
- DATA_W, 8, magnitude width (unsigned).
- IDX_W, 8, message index / degree width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a row; sampled only in IDLE.
- deg  input  IDX_W  row degree, latched on an accepted start.
- in_valid  input  1  message valid.
- in_ready  output  1  block accepts a message this cycle.
- in_sign  input  1  message sign (1 = negative).
- in_mag  input  DATA_W  message magnitude.
- out_valid  output  1  row result valid.
- out_ready  input  1  downstream accepts the result.
- min1  output  DATA_W  smallest magnitude in the row.
- min2  output  DATA_W  second-smallest magnitude.
- min1_idx  output  IDX_W  index (0-based arrival order) of min1.
- sign_prod  output  1  XOR of all signs in the row.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at clock edge): state=IDLE; in_ready=0, out_valid=0, busy=0; min1=min2=all-ones; min1_idx=0; sign_prod=0; count=0. Reset takes effect in any state and aborts a partial row with no output.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - start=1 and deg>=2: latch deg, clear count, set min1=min2=all-ones, min1_idx=0, sign_prod=0; go to LOAD.
  - start=1 and deg<2: ignored; stay in IDLE.
- LOAD:
  - in_ready=1 (combinational from state only).
  - A transfer occurs when in_valid=1 and in_ready=1. On each transfer:
    - in_mag < min1 (strict): min2<=min1, min1<=in_mag, min1_idx<=count.
    - else if in_mag < min2 (strict): min2<=in_mag.
    - else: min1/min2 unchanged.
    - sign_prod ^= in_sign; count++.
  - Ties: an equal earlier value keeps min1 and min1_idx (lowest index wins). A value equal to min1 fills min2 if min2 > min1.
  - When the transfer with count == deg-1 completes: go to DONE.
  - No transfer while in_valid=0; state held indefinitely.
  - start is ignored outside IDLE.
- DONE:
  - out_valid=1, in_ready=0. Outputs are held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE next cycle.
- Latency: last message accepted at edge t, out_valid=1 after edge t; earliest next start acceptance is one cycle after the output handshake.
- Outputs hold their last values in IDLE until the next accepted start clears them.
- count width is IDX_W; deg = 2^IDX_W-1 is the maximum row degree; count never wraps within a row.

Test Plan:
- Reset mid-LOAD: after 2 of deg=4 messages, assert rst_n=0 for 1 cycle -> state IDLE, out_valid=0, min1=min2=8'hFF, sign_prod=0, no result emitted.
- Basic row: deg=4, mags 9,3,7,5, signs 1,0,1,1, in_valid continuous -> out_valid 1 cycle after 4th transfer; min1=3, min2=5, min1_idx=1, sign_prod=1.
- Ties: deg=3, mags 4,4,6 -> min1=4, min1_idx=0, min2=4; deg=2, mags 0,0 -> min1=0, min2=0, min1_idx=0.
- Stall/backpressure: deg=5, in_valid toggled 1,0,0,1,... with mags 10,2,8,1,6 -> only valid cycles counted; min1=1, idx=3, min2=2. Then hold out_ready=0 for 4 cycles -> outputs stable, in_ready=0, out_valid=1 throughout.
- Illegal/ignored starts: start with deg=1 -> stays IDLE, busy=0. start pulsed during LOAD and DONE -> no effect. start in the output-handshake cycle -> ignored; accepted the following cycle.
- Extremes: DATA_W=8, deg=255, mags all 8'hFF except 8'h00 at index 254 -> min1=0, min1_idx=254, min2=8'hFF; count reaches 254 without wrap.

Source files
------------

// File: rtl/cnu_min_sched.sv
// Serial check-node min-sum scheduler: folds one sign/magnitude message per handshake into
// min1/min2/min1_idx/sign parity for a row of programmable degree, then offers the result.
module cnu_min_sched #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  deg,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [DATA_W-1:0] in_mag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] min1,
  output logic [DATA_W-1:0] min2,
  output logic [IDX_W-1:0]  min1_idx,
  output logic              sign_prod,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam logic [DATA_W-1:0] MagMax = {DATA_W{1'b1}};

  state_e              state_q;
  logic [IDX_W-1:0]    deg_q;
  logic [IDX_W-1:0]    count_q;
  logic [DATA_W-1:0]   min1_q;
  logic [DATA_W-1:0]   min2_q;
  logic [IDX_W-1:0]    min1_idx_q;
  logic                sign_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      deg_q      <= '0;
      count_q    <= '0;
      min1_q     <= MagMax;
      min2_q     <= MagMax;
      min1_idx_q <= '0;
      sign_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Degrees below 2 have no meaningful min2, so such starts are dropped.
          if (start && (deg > IDX_W'(1))) begin
            state_q    <= StLoad;
            deg_q      <= deg;
            count_q    <= '0;
            min1_q     <= MagMax;
            min2_q     <= MagMax;
            min1_idx_q <= '0;
            sign_q     <= 1'b0;
          end
        end
        StLoad: begin
          if (in_valid) begin
            // Strict compares: on a tie the earlier message keeps min1 and its index.
            if (in_mag < min1_q) begin
              min2_q     <= min1_q;
              min1_q     <= in_mag;
              min1_idx_q <= count_q;
            end else if (in_mag < min2_q) begin
              min2_q <= in_mag;
            end
            sign_q  <= sign_q ^ in_sign;
            count_q <= count_q + IDX_W'(1);
            if (count_q == deg_q - IDX_W'(1)) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign min1      = min1_q;
  assign min2      = min2_q;
  assign min1_idx  = min1_idx_q;
  assign sign_prod = sign_q;

endmodule

// File: tb/tb_cnu_min_sched.sv
// Bench for cnu_min_sched: table of rows with expected results queued at stimulus time,
// plus hand-written reset, ignored-start, backpressure and maximum-degree sequences.
module tb_cnu_min_sched;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] deg;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [7:0] in_mag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] min1;
  logic [7:0] min2;
  logic [7:0] min1_idx;
  logic       sign_prod;
  logic       busy;

  cnu_min_sched #(
    .DATA_W(8),
    .IDX_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .deg      (deg),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_mag   (in_mag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .min1     (min1),
    .min2     (min2),
    .min1_idx (min1_idx),
    .sign_prod(sign_prod),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] m1;
    logic [7:0] m2;
    logic [7:0] idx;
    logic       sp;
  } res_t;

  typedef struct {
    int              d;
    logic [0:7][7:0] mags;
    logic [0:7]      signs;
    bit              stall;
    int              hold;
    bit              hs_start;
    res_t            exp;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[6];
  int   checks;
  int   errors;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_row(input int d);
    chk("idle_before_start", int'(busy), 0);
    start = 1'b1;
    deg   = 8'(d);
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic send(input logic [7:0] mag, input logic sgn);
    chk("in_ready_load", int'(in_ready), 1);
    in_valid = 1'b1;
    in_mag   = mag;
    in_sign  = sgn;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for a result, checks it against the queue head, optionally stalls the handshake.
  task automatic collect(input int hold, input bit hs_start);
    res_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_result: got result expected none");
      return;
    end
    e = exp_q.pop_front();
    chk("min1", int'(min1), int'(e.m1));
    chk("min2", int'(min2), int'(e.m2));
    chk("min1_idx", int'(min1_idx), int'(e.idx));
    chk("sign_prod", int'(sign_prod), int'(e.sp));
    start = hs_start;
    deg   = 8'd3;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_min1", int'(min1), int'(e.m1));
      chk("hold_min2", int'(min2), int'(e.m2));
      chk("hold_idx", int'(min1_idx), int'(e.idx));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_out_valid", int'(out_valid), 0);
    chk("post_hs_busy", int'(busy), 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    deg      = 8'd0;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_mag   = 8'd0;
    out_ready = 1'b0;

    vecs[0] = '{4, {8'd9, 8'd3, 8'd7, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0}, 8'b1011_0000, 0, 0, 0,
                '{8'd3, 8'd5, 8'd1, 1'b1}};
    vecs[1] = '{3, {8'd4, 8'd4, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'b0000_0000, 0, 0, 0,
                '{8'd4, 8'd4, 8'd0, 1'b0}};
    vecs[2] = '{2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'b1100_0000, 0, 0, 0,
                '{8'd0, 8'd0, 8'd0, 1'b0}};
    vecs[3] = '{8, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'b1111_1111, 0, 0, 0,
                '{8'd1, 8'd2, 8'd7, 1'b0}};
    vecs[4] = '{3, {8'd7, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'b0010_0000, 0, 0, 0,
                '{8'd5, 8'd5, 8'd1, 1'b1}};
    vecs[5] = '{5, {8'd10, 8'd2, 8'd8, 8'd1, 8'd6, 8'd0, 8'd0, 8'd0}, 8'b0110_1000, 1, 4, 1,
                '{8'd1, 8'd2, 8'd3, 1'b1}};

    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_min1", int'(min1), 255);
    chk("rst_min2", int'(min2), 255);
    chk("rst_idx", int'(min1_idx), 0);
    chk("rst_sign", int'(sign_prod), 0);

    // Reset part-way through a row must abort it silently.
    start_row(4);
    send(8'd1, 1'b1);
    send(8'd2, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_min1", int'(min1), 255);
    chk("midrst_min2", int'(min2), 255);
    chk("midrst_sign", int'(sign_prod), 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (out_valid) seen++;
      end
      chk("midrst_no_result", seen, 0);
    end

    // Degrees below 2 are ignored.
    start = 1'b1;
    deg   = 8'd1;
    tick();
    chk("deg1_busy", int'(busy), 0);
    deg = 8'd0;
    tick();
    chk("deg0_busy", int'(busy), 0);
    start = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      start_row(vecs[v].d);
      for (int j = 0; j < vecs[v].d; j++) begin
        send(vecs[v].mags[j], vecs[v].signs[j]);
        if (vecs[v].stall && j < vecs[v].d - 1) begin
          repeat (2) begin
            tick();
            chk("stall_in_ready", int'(in_ready), 1);
            chk("stall_out_valid", int'(out_valid), 0);
          end
        end
      end
      exp_q.push_back(vecs[v].exp);
      collect(vecs[v].hold, vecs[v].hs_start);
      if (vecs[v].hs_start) begin
        // start held through the handshake cycle is accepted on the following edge.
        tick();
        start = 1'b0;
        chk("late_start_busy", int'(busy), 1);
        send(8'd20, 1'b0);
        send(8'd30, 1'b1);
        send(8'd10, 1'b0);
        exp_q.push_back('{8'd10, 8'd20, 8'd2, 1'b1});
        collect(0, 0);
      end
    end

    // start pulsed during LOAD must not relatch deg.
    start_row(2);
    send(8'd5, 1'b0);
    start = 1'b1;
    deg   = 8'd7;
    tick();
    start = 1'b0;
    send(8'd6, 1'b0);
    chk("load_start_done", int'(out_valid), 1);
    exp_q.push_back('{8'd5, 8'd6, 8'd0, 1'b0});
    collect(0, 0);

    // Maximum degree: count runs to 254 without wrapping.
    start_row(255);
    for (int i = 0; i < 254; i++) send(8'hFF, 1'b0);
    chk("max_not_done_early", int'(out_valid), 0);
    chk("max_busy", int'(busy), 1);
    send(8'h00, 1'b0);
    exp_q.push_back('{8'd0, 8'hFF, 8'd254, 1'b0});
    collect(0, 0);

    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
